dtpu_tile_sequencer: RTL and testbench

Next-generation control sequencer for the Cogitantium DTPU core, sized for an arbitrary ROWS x COLUMNS MXU. It fetches the job configuration from the CSR BRAM and loads ROWS weight words from the weight BRAM, with optional reuse of weights already loaded. It then streams N activation vectors through the MXU and drains ROWS results per vector to the output FIFO. Both FIFOs apply back-pressure, and the block exposes an ap_ctrl_chain style start/done handshake. It drives the enables of the ls_array/mxu datapath; it never touches data buses.

---
 rtl/dtpu_tile_sequencer_if.sv | 42 ++++
 rtl/dtpu_tile_sequencer.sv | 170 +++++++++++++++++
 tb/tb_dtpu_tile_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dtpu_tile_sequencer_if.sv
// Control/handshake bundle between the DTPU tile sequencer and its CSR BRAM,
// weight BRAM, activation/result FIFOs and the ls_array/mxu datapath enables.
interface dtpu_tile_sequencer_if #(
  parameter int ROWS                 = 3,
  parameter int ADDRESS_SIZE_CSR     = 32,
  parameter int ADDRESS_SIZE_WMEMORY = 32,
  parameter int DATA_WIDTH_CSR       = 8
);
  logic                            cs_start;
  logic                            cs_continue;
  logic                            cs_ready;
  logic                            cs_done;
  logic                            cs_idle;
  logic                            csr_ce;
  logic [ADDRESS_SIZE_CSR-1:0]     csr_address;
  logic [DATA_WIDTH_CSR-1:0]       csr_dout;
  logic                            wm_ce;
  logic [ADDRESS_SIZE_WMEMORY-1:0] wm_address;
  logic                            weight_shift;
  logic                            infifo_is_empty;
  logic                            infifo_read;
  logic                            outfifo_is_full;
  logic                            outfifo_write;
  logic [$clog2(ROWS):0]           out_sel;
  logic                            mxu_enable;
  logic [1:0]                      data_precision;
  logic [3:0]                      state_out;

  modport master (
    input  cs_start, cs_continue, csr_dout, infifo_is_empty, outfifo_is_full,
    output cs_ready, cs_done, cs_idle, csr_ce, csr_address, wm_ce, wm_address,
           weight_shift, infifo_read, outfifo_write, out_sel, mxu_enable,
           data_precision, state_out
  );

  modport slave (
    output cs_start, cs_continue, csr_dout, infifo_is_empty, outfifo_is_full,
    input  cs_ready, cs_done, cs_idle, csr_ce, csr_address, wm_ce, wm_address,
           weight_shift, infifo_read, outfifo_write, out_sel, mxu_enable,
           data_precision, state_out
  );
endinterface

// File: rtl/dtpu_tile_sequencer.sv
// DTPU tile sequencer: fetches job config from CSR, loads weights, streams N
// activation vectors through the MXU and drains ROWS results per vector.
module dtpu_tile_sequencer #(
  parameter int ROWS                 = 3,
  parameter int COLUMNS              = 3,
  parameter int MXU_LATENCY          = ROWS + COLUMNS + 1,
  parameter int ADDRESS_SIZE_CSR     = 32,
  parameter int ADDRESS_SIZE_WMEMORY = 32,
  parameter int DATA_WIDTH_CSR       = 8,
  parameter int WM_BASE              = 0
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic                         enable,
  dtpu_tile_sequencer_if.master        bus
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_CFG0  = 4'd1;
  localparam logic [3:0] S_CFG1  = 4'd2;
  localparam logic [3:0] S_CFG2  = 4'd3;
  localparam logic [3:0] S_LDW   = 4'd4;
  localparam logic [3:0] S_LDA   = 4'd5;
  localparam logic [3:0] S_COMP  = 4'd6;
  localparam logic [3:0] S_STORE = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  localparam int WW = $clog2(ROWS + 1);
  localparam int AW = $clog2(COLUMNS + 1);
  localparam int CW = $clog2(MXU_LATENCY + 1);
  localparam int RW = $clog2(ROWS) + 1;
  localparam int VW = DATA_WIDTH_CSR + 1;

  logic [3:0]                state_q, state_d;
  logic [WW-1:0]             w_cnt_q, w_cnt_d;
  logic [AW-1:0]             a_cnt_q, a_cnt_d;
  logic [CW-1:0]             c_cnt_q, c_cnt_d;
  logic [RW-1:0]             r_cnt_q, r_cnt_d;
  logic [VW-1:0]             vec_cnt_q, vec_cnt_d, vec_inc;
  logic [DATA_WIDTH_CSR-1:0] n_q, n_d;
  logic [1:0]                prec_q, prec_d;
  logic                      reuse_q, reuse_d;
  logic                      wvalid_q, wvalid_d;
  logic                      run, rd_fire, wr_fire, w_active;

  // Strobes are quiet while frozen and during the reset cycle itself.
  assign run      = enable && aresetn;
  assign rd_fire  = (state_q == S_LDA) && !bus.infifo_is_empty;
  assign wr_fire  = (state_q == S_STORE) && !bus.outfifo_is_full;
  assign w_active = (state_q == S_LDW) && (w_cnt_q != WW'(ROWS));
  assign vec_inc  = vec_cnt_q + VW'(1);

  always_comb begin
    // NOTE: every next-state signal defaults to its hold value, so no branch can infer a latch.
    state_d   = state_q;
    w_cnt_d   = w_cnt_q;
    a_cnt_d   = a_cnt_q;
    c_cnt_d   = c_cnt_q;
    r_cnt_d   = r_cnt_q;
    vec_cnt_d = vec_cnt_q;
    n_d       = n_q;
    prec_d    = prec_q;
    reuse_d   = reuse_q;
    wvalid_d  = wvalid_q;
    case (state_q)
      S_IDLE: if (bus.cs_start) state_d = S_CFG0;
      S_CFG0: state_d = S_CFG1;
      S_CFG1: begin
        prec_d  = bus.csr_dout[1:0];
        reuse_d = bus.csr_dout[2];
        state_d = S_CFG2;
      end
      S_CFG2: begin
        n_d = bus.csr_dout;
        if (bus.csr_dout == '0)        state_d = S_DONE;
        else if (reuse_q && wvalid_q)  state_d = S_LDA;
        else                           state_d = S_LDW;
      end
      // The extra cycle at w_cnt==ROWS shifts in the last word returned by the BRAM.
      S_LDW: begin
        if (w_active) begin
          w_cnt_d = w_cnt_q + WW'(1);
        end else begin
          w_cnt_d  = '0;
          wvalid_d = 1'b1;
          state_d  = S_LDA;
        end
      end
      S_LDA: begin
        if (rd_fire) begin
          if (a_cnt_q == AW'(COLUMNS - 1)) begin
            a_cnt_d = '0;
            state_d = S_COMP;
          end else begin
            a_cnt_d = a_cnt_q + AW'(1);
          end
        end
      end
      S_COMP: begin
        if (c_cnt_q == CW'(MXU_LATENCY - 1)) begin
          c_cnt_d = '0;
          state_d = S_STORE;
        end else begin
          c_cnt_d = c_cnt_q + CW'(1);
        end
      end
      S_STORE: begin
        if (wr_fire) begin
          if (r_cnt_q == RW'(ROWS - 1)) begin
            r_cnt_d   = '0;
            vec_cnt_d = vec_inc;
            state_d   = (vec_inc == VW'(n_q)) ? S_DONE : S_LDA;
          end else begin
            r_cnt_d = r_cnt_q + RW'(1);
          end
        end
      end
      S_DONE: begin
        if (bus.cs_continue) begin
          vec_cnt_d = '0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all of them sample pre-edge values.
    if (!aresetn) begin
      state_q   <= S_IDLE;
      w_cnt_q   <= '0;
      a_cnt_q   <= '0;
      c_cnt_q   <= '0;
      r_cnt_q   <= '0;
      vec_cnt_q <= '0;
      n_q       <= '0;
      prec_q    <= '0;
      reuse_q   <= 1'b0;
      wvalid_q  <= 1'b0;
    end else if (enable) begin
      state_q   <= state_d;
      w_cnt_q   <= w_cnt_d;
      a_cnt_q   <= a_cnt_d;
      c_cnt_q   <= c_cnt_d;
      r_cnt_q   <= r_cnt_d;
      vec_cnt_q <= vec_cnt_d;
      n_q       <= n_d;
      prec_q    <= prec_d;
      reuse_q   <= reuse_d;
      wvalid_q  <= wvalid_d;
    end
  end

  assign bus.cs_ready       = run && (state_q == S_CFG2);
  assign bus.cs_done        = (state_q == S_DONE);
  assign bus.cs_idle        = (state_q == S_IDLE);
  assign bus.csr_ce         = run && ((state_q == S_CFG0) || (state_q == S_CFG1));
  assign bus.csr_address    = (state_q == S_CFG1) ? ADDRESS_SIZE_CSR'(1) : '0;
  assign bus.wm_ce          = run && w_active;
  assign bus.wm_address     = w_active ? ADDRESS_SIZE_WMEMORY'(WM_BASE) + ADDRESS_SIZE_WMEMORY'(w_cnt_q) : '0;
  assign bus.weight_shift   = run && (state_q == S_LDW) && (w_cnt_q != '0);
  assign bus.infifo_read    = run && rd_fire;
  assign bus.outfifo_write  = run && wr_fire;
  assign bus.out_sel        = (state_q == S_STORE) ? r_cnt_q : '0;
  assign bus.mxu_enable     = run && (rd_fire || wr_fire || (state_q == S_COMP));
  assign bus.data_precision = prec_q;
  assign bus.state_out      = state_q;

endmodule

// File: tb/tb_dtpu_tile_sequencer.sv
// Self-checking bench for dtpu_tile_sequencer: randomized FIFO/enable stimulus
// checked against job-level expectations (event counts, orderings, timing).
module tb_dtpu_tile_sequencer;
  localparam int ROWS = 3;
  localparam int COLUMNS = 3;
  localparam int LAT = ROWS + COLUMNS + 1;
  localparam int ASC = 32;
  localparam int ASW = 32;
  localparam int DW = 8;
  localparam int WM_BASE = 0;

  logic clk = 1'b0;
  logic aresetn;
  logic enable;
  always #5 clk = ~clk;

  dtpu_tile_sequencer_if #(.ROWS(ROWS), .ADDRESS_SIZE_CSR(ASC),
    .ADDRESS_SIZE_WMEMORY(ASW), .DATA_WIDTH_CSR(DW)) bus ();

  dtpu_tile_sequencer #(.ROWS(ROWS), .COLUMNS(COLUMNS), .MXU_LATENCY(LAT),
    .ADDRESS_SIZE_CSR(ASC), .ADDRESS_SIZE_WMEMORY(ASW), .DATA_WIDTH_CSR(DW),
    .WM_BASE(WM_BASE)) dut (
    .clk(clk), .aresetn(aresetn), .enable(enable), .bus(bus));

  // CSR BRAM model, 1-cycle read latency
  logic [DW-1:0] csr_mem [2];
  always @(posedge clk) if (bus.csr_ce) bus.csr_dout <= csr_mem[bus.csr_address[0]];

  int tests_run, tests_failed;
  bit wv_model;  // weights already loaded since the last reset

  // Per-job observations
  int ws_cnt, ws_bad, rd, rd_empty, wr, wr_full, sel_bad, comp_cyc, comp_bad;
  int mxu_bad, mxu_idle, ready_cnt, ready_cyc, after_cfg2, dis_bad, comp_frozen;
  int lda_empty, done_drop;
  logic [ASW-1:0] wm_q[$];
  logic [1:0] prec_seen;
  bit idle_ok, timed_out;

  task automatic do_reset();
    @(posedge clk); #1;
    aresetn = 1'b0; enable = 1'b1;
    bus.cs_start = 1'b0; bus.cs_continue = 1'b0;
    bus.infifo_is_empty = 1'b0; bus.outfifo_is_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    wv_model = 1'b0;
  endtask

  task automatic run_job(input string name, input logic [7:0] c0, input logic [7:0] n,
                         input int e_mode, input int f_mode, input int en_mode);
    int done_seen = 0, hold, stall_used = 0, frz_used = 0, exp_after, exp_ws;
    bit finished = 0, cont_acc = 0, prev_wm = 0, exp_load;
    logic [3:0] prev_state = 4'd0;
    ws_cnt = 0; ws_bad = 0; rd = 0; rd_empty = 0; wr = 0; wr_full = 0; sel_bad = 0;
    comp_cyc = 0; comp_bad = 0; mxu_bad = 0; mxu_idle = 0; ready_cnt = 0; ready_cyc = -1;
    after_cfg2 = -1; dis_bad = 0; comp_frozen = 0; lda_empty = 0; done_drop = 0;
    wm_q.delete(); idle_ok = 0;
    csr_mem[0] = c0; csr_mem[1] = n;
    hold = $urandom_range(1, 3);
    exp_load = (n != 0) && !(c0[2] && wv_model);
    exp_after = (n == 0) ? 8 : (exp_load ? 4 : 5);
    exp_ws = exp_load ? ROWS : 0;

    for (int k = 0; k < 4000 && !finished; k++) begin
      @(posedge clk); #1;
      bus.cs_start = (k == 0) || (done_seen > 0 && !cont_acc && $urandom_range(0, 1) == 1);
      bus.cs_continue = (done_seen >= hold) && !cont_acc;
      enable = 1'b1;
      if (en_mode == 1 && k != 0) enable = ($urandom_range(0, 3) != 0);
      if (en_mode == 2 && comp_cyc == 2 && frz_used < 4) begin enable = 1'b0; frz_used++; end
      bus.infifo_is_empty = 1'b0;
      if (e_mode == 1) bus.infifo_is_empty = 1'($urandom_range(0, 1));
      if (e_mode == 2 && rd == 1 && stall_used < 5) begin bus.infifo_is_empty = 1'b1; stall_used++; end
      bus.outfifo_is_full = 1'b0;
      if (f_mode == 1) bus.outfifo_is_full = 1'($urandom_range(0, 1));
      if (f_mode == 2) bus.outfifo_is_full = k[0];

      @(negedge clk);
      if (cont_acc) begin
        idle_ok = bus.cs_idle && !bus.cs_done;
        finished = 1;
      end else begin
        if (done_seen > 0 && !bus.cs_done) done_drop++;
        if (bus.cs_done) begin
          done_seen++;
          if (bus.cs_continue && enable) cont_acc = 1;
        end
        if (!enable) begin
          if (bus.csr_ce | bus.wm_ce | bus.weight_shift | bus.infifo_read |
              bus.outfifo_write | bus.mxu_enable) dis_bad++;
          if (bus.state_out == 4'd6) comp_frozen++;
        end else begin
          if (bus.cs_ready) begin ready_cnt++; if (ready_cyc < 0) ready_cyc = k; end
          if (bus.wm_ce) wm_q.push_back(bus.wm_address);
          if (bus.weight_shift) begin ws_cnt++; if (!prev_wm) ws_bad++; end
          prev_wm = bus.wm_ce;
          if (bus.state_out == 4'd5 && bus.infifo_is_empty) lda_empty++;
          if (bus.state_out == 4'd5 && bus.mxu_enable !== bus.infifo_read) mxu_bad++;
          if (bus.state_out == 4'd7 && bus.mxu_enable !== bus.outfifo_write) mxu_bad++;
          if (bus.mxu_enable && !bus.infifo_read && !bus.outfifo_write) mxu_idle++;
          if (bus.infifo_read) begin rd++; if (bus.infifo_is_empty) rd_empty++; end
          if (bus.outfifo_write) begin
            if (bus.outfifo_is_full) wr_full++;
            if (int'(bus.out_sel) != wr % ROWS) sel_bad++;
            wr++;
          end
          if (bus.state_out == 4'd6) begin
            comp_cyc++;
            if (rd != (wr / ROWS + 1) * COLUMNS) comp_bad++;
          end
          if (prev_state == 4'd3 && bus.state_out != 4'd3 && after_cfg2 < 0)
            after_cfg2 = int'(bus.state_out);
          prev_state = bus.state_out;
        end
      end
    end
    timed_out = !finished;
    prec_seen = bus.data_precision;
    bus.cs_start = 1'b0; bus.cs_continue = 1'b0;

    tests_run++;
    if (timed_out) begin tests_failed++; $display("FAIL %s/timeout: got no completion within budget, want done+continue", name); end
    tests_run++;
    if (wm_q.size() != exp_ws) begin tests_failed++; $display("FAIL %s/wm_ce_count: got %0d, want %0d", name, wm_q.size(), exp_ws); end
    else for (int i = 0; i < exp_ws; i++) begin
      tests_run++;
      if (wm_q[i] !== ASW'(WM_BASE + i)) begin tests_failed++; $display("FAIL %s/wm_address[%0d]: got %0d, want %0d", name, i, wm_q[i], WM_BASE + i); end
    end
    tests_run++;
    if (ws_cnt != exp_ws || ws_bad != 0) begin tests_failed++; $display("FAIL %s/weight_shift: got %0d (%0d unaligned), want %0d aligned", name, ws_cnt, ws_bad, exp_ws); end
    tests_run++;
    if (rd != n * COLUMNS || rd_empty != 0) begin tests_failed++; $display("FAIL %s/infifo_read: got %0d (%0d while empty), want %0d", name, rd, rd_empty, n * COLUMNS); end
    tests_run++;
    if (wr != n * ROWS || wr_full != 0) begin tests_failed++; $display("FAIL %s/outfifo_write: got %0d (%0d while full), want %0d", name, wr, wr_full, n * ROWS); end
    tests_run++;
    if (sel_bad != 0) begin tests_failed++; $display("FAIL %s/out_sel: got %0d out-of-order writes, want 0", name, sel_bad); end
    tests_run++;
    if (comp_cyc != n * LAT || mxu_idle != n * LAT || comp_bad != 0) begin tests_failed++; $display("FAIL %s/comp: got %0d comp cycles, %0d compute mxu cycles, %0d early, want %0d, %0d, 0", name, comp_cyc, mxu_idle, comp_bad, n * LAT, n * LAT); end
    tests_run++;
    if (mxu_bad != 0) begin tests_failed++; $display("FAIL %s/mxu_enable: got %0d cycles differing from fifo strobe, want 0", name, mxu_bad); end
    tests_run++;
    if (after_cfg2 != exp_after) begin tests_failed++; $display("FAIL %s/after_cfg2: got state %0d, want %0d", name, after_cfg2, exp_after); end
    tests_run++;
    if (prec_seen !== c0[1:0]) begin tests_failed++; $display("FAIL %s/data_precision: got %0d, want %0d", name, prec_seen, c0[1:0]); end
    tests_run++;
    if (ready_cnt != 1) begin tests_failed++; $display("FAIL %s/cs_ready: got %0d pulses, want 1", name, ready_cnt); end
    tests_run++;
    if (done_drop != 0 || !idle_ok) begin tests_failed++; $display("FAIL %s/done_handshake: got %0d drops, idle_after=%0d, want 0, 1", name, done_drop, idle_ok); end
    tests_run++;
    if (dis_bad != 0) begin tests_failed++; $display("FAIL %s/enable_low_strobes: got %0d cycles with strobes, want 0", name, dis_bad); end
    if (exp_load) wv_model = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge clk); #1 aresetn = 1'b0;
    @(posedge clk); @(negedge clk);
    tests_run++;
    if (bus.cs_idle !== 1'b1 || bus.state_out !== 4'd0) begin tests_failed++; $display("FAIL reset/idle: got idle=%0d state=%0d, want 1, 0", bus.cs_idle, bus.state_out); end
    tests_run++;
    if ({bus.csr_ce, bus.wm_ce, bus.weight_shift, bus.infifo_read, bus.outfifo_write,
         bus.mxu_enable, bus.cs_ready, bus.cs_done} !== 8'h00) begin tests_failed++; $display("FAIL reset/strobes: got nonzero strobe, want all 0"); end
    tests_run++;
    if (bus.csr_address !== '0 || bus.wm_address !== '0 || bus.out_sel !== '0 || bus.data_precision !== 2'd0) begin
      tests_failed++; $display("FAIL reset/buses: got csr=%0d wm=%0d sel=%0d prec=%0d, want all 0", bus.csr_address, bus.wm_address, bus.out_sel, bus.data_precision); end
    #1 aresetn = 1'b1;
    wv_model = 1'b0;
  endtask

  task automatic test_default_job();
    run_job("default", 8'h01, 8'd2, 0, 0, 0);
    tests_run++;
    if (ready_cyc != 3) begin tests_failed++; $display("FAIL default/ready_cycle: got %0d, want 3", ready_cyc); end
  endtask

  task automatic test_reuse();
    run_job("reuse", 8'h04, 8'd1, 0, 0, 0);
    do_reset();
    run_job("reuse_after_reset", 8'h04, 8'd1, 0, 0, 0);
  endtask

  task automatic test_infifo_stall();
    run_job("infifo_stall", 8'h02, 8'd2, 2, 0, 0);
    tests_run++;
    if (lda_empty != 5) begin tests_failed++; $display("FAIL infifo_stall/empty_cycles: got %0d, want 5", lda_empty); end
  endtask

  task automatic test_outfifo_backpressure();
    run_job("outfifo_toggle", 8'h03, 8'd2, 0, 2, 0);
  endtask

  task automatic test_zero_vectors();
    run_job("zero_n", 8'h00, 8'd0, 0, 0, 0);
  endtask

  task automatic test_enable_freeze();
    run_job("enable_freeze", 8'h01, 8'd1, 0, 0, 2);
    tests_run++;
    if (comp_frozen != 4) begin tests_failed++; $display("FAIL enable_freeze/frozen_comp: got %0d, want 4", comp_frozen); end
  endtask

  task automatic test_reset_mid_store();
    bit seen = 0;
    csr_mem[0] = 8'h05; csr_mem[1] = 8'd2;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(posedge clk); #1;
      bus.cs_start = (k == 0); enable = 1'b1;
      bus.infifo_is_empty = 1'b0; bus.outfifo_is_full = 1'b0;
      @(negedge clk);
      if (bus.state_out == 4'd7 && bus.outfifo_write) seen = 1;
    end
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL reset_mid_store/reach_store: got no STORE write, want one"); end
    @(posedge clk); #1 aresetn = 1'b0;
    @(posedge clk); #1 aresetn = 1'b1;
    wv_model = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.state_out !== 4'd0 || bus.cs_idle !== 1'b1) begin tests_failed++; $display("FAIL reset_mid_store/state: got state=%0d idle=%0d, want 0, 1", bus.state_out, bus.cs_idle); end
    tests_run++;
    if ({bus.csr_ce, bus.wm_ce, bus.weight_shift, bus.infifo_read, bus.outfifo_write, bus.mxu_enable} !== 6'h00
        || bus.out_sel !== '0 || bus.data_precision !== 2'd0) begin
      tests_failed++; $display("FAIL reset_mid_store/outputs: got residual strobe or nonzero sel=%0d prec=%0d, want all 0", bus.out_sel, bus.data_precision); end
    run_job("after_abort", 8'h04, 8'd1, 0, 0, 0);
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 6; j++)
      run_job($sformatf("random%0d", j), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 4)), 1, 1, 1);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; wv_model = 1'b0;
    aresetn = 1'b0; enable = 1'b1;
    bus.cs_start = 1'b0; bus.cs_continue = 1'b0;
    bus.infifo_is_empty = 1'b0; bus.outfifo_is_full = 1'b0;
    test_reset();
    test_default_job();
    test_reuse();
    test_infifo_stall();
    test_outfifo_backpressure();
    test_zero_vectors();
    test_enable_freeze();
    test_reset_mid_store();
    test_random_jobs();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
